// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the DTACK / wait-state generator.
//   state_t      : bus-cycle FSM states
//   WS_W_DEF     : default wait-count width
//   TO_W_DEF     : default timeout-counter width
//   IDX_W        : width of region index buses (ws_idx, sel_idx)
//   unmapped_idx : sel_idx code reported for a cycle that hit no region
package bus_ctrl_pkg;

  localparam int unsigned WS_W_DEF = 4;
  localparam int unsigned TO_W_DEF = 8;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    COUNT,
    ACK,
    BERR
  } state_t;

  // Unmapped cycles report NREG; with NREG=16 this wraps to 0 in IDX_W bits.
  function automatic logic [IDX_W-1:0] unmapped_idx(input int unsigned nreg);
    return IDX_W'(nreg);
  endfunction

endpackage

// File: rtl/dtack_wait_gen_if.sv
// CPU-side bus bundle for dtack_wait_gen.
//   master : address decoders / CPU / table writer (drive strobes and selects)
//   slave  : dtack_wait_gen (drives DTACKn, BERRn, busy, sel_idx)
interface dtack_wait_gen_if #(
  parameter int unsigned NREG = 4,
  parameter int unsigned WS_W = bus_ctrl_pkg::WS_W_DEF
);
  import bus_ctrl_pkg::*;

  logic             AS_b;
  logic [NREG-1:0]  region_sel_b;
  logic             WAIT_b;
  logic             VRDTACK_b;
  logic             ws_we;
  logic [IDX_W-1:0] ws_idx;
  logic [WS_W-1:0]  ws_val;
  logic             DTACKn;
  logic             BERRn;
  logic             busy;
  logic [IDX_W-1:0] sel_idx;

  modport master (
    output AS_b, region_sel_b, WAIT_b, VRDTACK_b, ws_we, ws_idx, ws_val,
    input  DTACKn, BERRn, busy, sel_idx
  );

  modport slave (
    input  AS_b, region_sel_b, WAIT_b, VRDTACK_b, ws_we, ws_idx, ws_val,
    output DTACKn, BERRn, busy, sel_idx
  );

endinterface

// File: rtl/dtack_wait_gen_prio.sv
// Lowest-index-wins priority encoder over active-low region selects.
//   sel_b   : NREG active-low selects
//   idx_c   : index of the lowest low select (unmapped code when none)
//   valid_c : at least one select is low
module region_prio_enc
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic [NREG-1:0]  sel_b,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // Scan high to low so the lowest asserted index is the last to write.
  always_comb begin
    idx_c   = unmapped_idx(NREG);
    valid_c = 1'b0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (!sel_b[i]) begin
        idx_c   = IDX_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtack_wait_gen.sv
// DTACK / wait-state / bus-timeout generator for NREG decoded regions.
//   MCKR    : system / CPU clock
//   SYSRES  : synchronous active-high reset
//   bus     : slave side of dtack_wait_gen_if
//             in : AS_b, region_sel_b, WAIT_b, VRDTACK_b, ws_we, ws_idx, ws_val
//             out: DTACKn, BERRn, busy, sel_idx (all registered)
module dtack_wait_gen
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned          NREG     = 4,
  parameter int unsigned          WS_W     = WS_W_DEF,
  parameter logic [NREG*WS_W-1:0] WS_INIT  = {NREG{WS_W'(2)}},
  parameter logic [NREG-1:0]      EXT_MASK = '0,
  parameter int unsigned          TO_W     = TO_W_DEF,
  parameter int unsigned          TIMEOUT  = 255
) (
  input  logic             MCKR,
  input  logic             SYSRES,
  dtack_wait_gen_if.slave  bus
);

  state_t            state;
  logic [WS_W-1:0]   ws_tab [NREG];
  logic [WS_W-1:0]   cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              ext_req;
  logic              mapped;

  logic [IDX_W-1:0]  enc_idx_c;
  logic              enc_valid_c;
  logic [WS_W-1:0]   ws_pick_c;
  logic              ext_pick_c;
  logic [TO_W-1:0]   to_inc_c;
  logic              timeout_hit_c;
  logic              ack_ok_c;

  region_prio_enc #(.NREG(NREG)) u_prio (
    .sel_b   (bus.region_sel_b),
    .idx_c   (enc_idx_c),
    .valid_c (enc_valid_c)
  );

  // Per-region lookup of wait count and external-ack requirement.
  always_comb begin
    ws_pick_c  = '0;
    ext_pick_c = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (enc_idx_c == IDX_W'(i)) begin
        ws_pick_c  = ws_tab[i];
        ext_pick_c = EXT_MASK[i];
      end
    end
  end

  // Saturating timeout increment; BERR fires on the edge the count reaches TIMEOUT.
  always_comb begin
    to_inc_c      = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
    timeout_hit_c = (TIMEOUT != 0) && (to_inc_c == TO_W'(TIMEOUT));
    ack_ok_c      = bus.WAIT_b && (cnt == '0) && mapped && (!ext_req || !bus.VRDTACK_b);
  end

  // Wait table; indices >= NREG match no entry and are dropped.
  always_ff @(posedge MCKR) begin
    if (SYSRES) begin
      for (int i = 0; i < int'(NREG); i++) begin
        ws_tab[i] <= WS_INIT[i*WS_W +: WS_W];
      end
    end else if (bus.ws_we) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (bus.ws_idx == IDX_W'(i)) begin
          ws_tab[i] <= bus.ws_val;
        end
      end
    end
  end

  // Bus-cycle FSM with registered outputs.
  always_ff @(posedge MCKR) begin
    if (SYSRES) begin
      state       <= IDLE;
      bus.DTACKn  <= 1'b1;
      bus.BERRn   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.sel_idx <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      ext_req     <= 1'b0;
      mapped      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.AS_b) begin
            state    <= DECODE;
            bus.busy <= 1'b1;
          end
        end

        DECODE: begin
          bus.sel_idx <= enc_idx_c;
          to_cnt      <= '0;
          if (bus.AS_b) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            mapped  <= enc_valid_c;
            cnt     <= enc_valid_c ? ws_pick_c : '0;
            ext_req <= enc_valid_c & ext_pick_c;
            state   <= COUNT;
          end
        end

        COUNT: begin
          to_cnt <= to_inc_c;
          // Abort beats timeout, which beats acknowledge.
          if (bus.AS_b) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (timeout_hit_c) begin
            state     <= BERR;
            bus.BERRn <= 1'b0;
          end else if (ack_ok_c) begin
            state      <= ACK;
            bus.DTACKn <= 1'b0;
          end else if (bus.WAIT_b && (cnt != '0)) begin
            cnt <= cnt - WS_W'(1);
          end
        end

        ACK: begin
          if (bus.AS_b) begin
            state      <= IDLE;
            bus.DTACKn <= 1'b1;
            bus.busy   <= 1'b0;
          end
        end

        BERR: begin
          if (bus.AS_b) begin
            state     <= IDLE;
            bus.BERRn <= 1'b1;
            bus.busy  <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          bus.DTACKn <= 1'b1;
          bus.BERRn  <= 1'b1;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtack_wait_gen.sv
// Self-checking bench for dtack_wait_gen: directed vector table, hand-written
// multi-cycle sequences, then randomized bus cycles against a cycle-outcome model.
module tb_dtack_wait_gen;
  import bus_ctrl_pkg::*;

  localparam int unsigned    NREG = 4;
  localparam int unsigned    WS_W = 4;
  localparam int unsigned    TMO  = 16;
  localparam logic [NREG-1:0] EXT = 4'b0100;

  logic MCKR = 1'b0;
  logic SYSRES;

  always #5 MCKR = ~MCKR;

  dtack_wait_gen_if #(.NREG(NREG), .WS_W(WS_W)) bus ();

  dtack_wait_gen #(
    .NREG(NREG), .WS_W(WS_W), .EXT_MASK(EXT), .TO_W(8), .TIMEOUT(TMO)
  ) dut (
    .MCKR   (MCKR),
    .SYSRES (SYSRES),
    .bus    (bus)
  );

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic       rst;
    logic       as_b;
    logic [3:0] sel_b;
    logic       wait_b;
    logic       vr_b;
    logic       we;
    logic [3:0] idx;
    logic [3:0] val;
    logic       e_dt;
    logic       e_be;
    logic       e_busy;
    logic [3:0] e_sel;
  } vec_t;

  function automatic vec_t mk(input logic rst, as_b, input logic [3:0] sel_b,
                              input logic wait_b, vr_b, we, input logic [3:0] idx, val,
                              input logic e_dt, e_be, e_busy, input logic [3:0] e_sel);
    vec_t r;
    r.rst = rst; r.as_b = as_b; r.sel_b = sel_b; r.wait_b = wait_b; r.vr_b = vr_b;
    r.we = we; r.idx = idx; r.val = val;
    r.e_dt = e_dt; r.e_be = e_be; r.e_busy = e_busy; r.e_sel = e_sel;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one edge's inputs, clock, then sample 1 time unit after the edge.
  task automatic apply(input logic rst, as_b, input logic [3:0] sel_b,
                       input logic wait_b, vr_b, we, input logic [3:0] idx, val);
    SYSRES           = rst;
    bus.AS_b         = as_b;
    bus.region_sel_b = sel_b;
    bus.WAIT_b       = wait_b;
    bus.VRDTACK_b    = vr_b;
    bus.ws_we        = we;
    bus.ws_idx       = idx;
    bus.ws_val       = val;
    @(posedge MCKR);
    #1;
  endtask

  task automatic cyc(input logic as_b, input logic [3:0] sel_b);
    apply(1'b0, as_b, sel_b, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
  endtask

  vec_t tbl [17];
  logic [3:0] ws_m [16];

  initial begin
    SYSRES = 1'b1;
    bus.AS_b = 1'b1; bus.region_sel_b = 4'hF; bus.WAIT_b = 1'b1; bus.VRDTACK_b = 1'b1;
    bus.ws_we = 1'b0; bus.ws_idx = 4'd0; bus.ws_val = 4'd0;

    // rst as sel  w  vr we idx val | dt be busy sel
    tbl[0]  = mk(1, 1, 4'hF, 1, 1, 0, 0, 0,  1, 1, 0, 0);
    tbl[1]  = mk(0, 1, 4'hF, 1, 1, 0, 0, 0,  1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  1, 1, 1, 0);
    tbl[3]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  1, 1, 1, 1);
    tbl[4]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  1, 1, 1, 1);
    tbl[5]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  1, 1, 1, 1);
    tbl[6]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  0, 1, 1, 1);
    tbl[7]  = mk(0, 0, 4'hD, 1, 1, 0, 0, 0,  0, 1, 1, 1);
    tbl[8]  = mk(0, 1, 4'hD, 1, 1, 0, 0, 0,  1, 1, 0, 1);
    tbl[9]  = mk(0, 1, 4'hF, 1, 1, 1, 0, 0,  1, 1, 0, 1);
    tbl[10] = mk(0, 0, 4'hE, 1, 1, 0, 0, 0,  1, 1, 1, 1);
    tbl[11] = mk(0, 0, 4'hE, 1, 1, 0, 0, 0,  1, 1, 1, 0);
    tbl[12] = mk(0, 0, 4'hE, 0, 1, 0, 0, 0,  1, 1, 1, 0);
    tbl[13] = mk(0, 0, 4'hE, 0, 1, 0, 0, 0,  1, 1, 1, 0);
    tbl[14] = mk(0, 0, 4'hE, 0, 1, 0, 0, 0,  1, 1, 1, 0);
    tbl[15] = mk(0, 0, 4'hE, 1, 1, 0, 0, 0,  0, 1, 1, 0);
    tbl[16] = mk(0, 1, 4'hE, 1, 1, 0, 0, 0,  1, 1, 0, 0);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst, tbl[i].as_b, tbl[i].sel_b, tbl[i].wait_b, tbl[i].vr_b,
            tbl[i].we, tbl[i].idx, tbl[i].val);
      chk($sformatf("tbl%0d_dtackn", i), bus.DTACKn, tbl[i].e_dt);
      chk($sformatf("tbl%0d_berrn", i), bus.BERRn, tbl[i].e_be);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_sel_idx", i), bus.sel_idx, tbl[i].e_sel);
    end

    // External-ack region 2 with ws=1: VRDTACK_b high for 6 edges, then low.
    apply(0, 1, 4'hF, 1, 1, 1, 4'd2, 4'd1);
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 4'hB, 1, 1, 0, 0, 0);
      chk($sformatf("ext_wait%0d", i), bus.DTACKn, 1);
    end
    apply(0, 0, 4'hB, 1, 0, 0, 0, 0);
    chk("ext_ack_dtackn", bus.DTACKn, 0);
    chk("ext_sel_idx", bus.sel_idx, 2);
    cyc(1'b1, 4'hF);
    chk("ext_release", bus.DTACKn, 1);

    // Unmapped cycle ends in BERR at k+1+TIMEOUT.
    for (int i = 0; i <= 16; i++) begin
      cyc(1'b0, 4'hF);
      chk($sformatf("to_pre_berrn%0d", i), bus.BERRn, 1);
      chk($sformatf("to_pre_dtackn%0d", i), bus.DTACKn, 1);
    end
    cyc(1'b0, 4'hF);
    chk("to_berrn", bus.BERRn, 0);
    chk("to_dtackn", bus.DTACKn, 1);
    chk("to_sel_idx", bus.sel_idx, NREG);
    cyc(1'b0, 4'hF);
    chk("to_hold_berrn", bus.BERRn, 0);
    cyc(1'b1, 4'hF);
    chk("to_release_berrn", bus.BERRn, 1);
    chk("to_release_busy", bus.busy, 0);

    // Regions 1 and 3 both selected: region 1 wins; mid-cycle write only affects the next cycle.
    cyc(1'b0, 4'h5);
    cyc(1'b0, 4'h5);
    chk("prio_sel_idx", bus.sel_idx, 1);
    apply(0, 0, 4'h5, 1, 1, 1, 4'd1, 4'd5);
    chk("prio_k2", bus.DTACKn, 1);
    cyc(1'b0, 4'h5);
    chk("prio_k3", bus.DTACKn, 1);
    cyc(1'b0, 4'h5);
    chk("prio_ack_old_ws", bus.DTACKn, 0);
    cyc(1'b1, 4'h5);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 4'h5);
      chk($sformatf("prio_new_wait%0d", i), bus.DTACKn, 1);
    end
    cyc(1'b0, 4'h5);
    chk("prio_ack_new_ws", bus.DTACKn, 0);
    cyc(1'b1, 4'h5);

    // Abort mid-COUNT: no DTACKn pulse.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h7);
      chk($sformatf("abort_cnt%0d", i), bus.DTACKn, 1);
    end
    cyc(1'b1, 4'h7);
    chk("abort_busy", bus.busy, 0);
    chk("abort_dtackn", bus.DTACKn, 1);
    cyc(1'b1, 4'hF);
    chk("abort_idle_dtackn", bus.DTACKn, 1);
    chk("abort_idle_berrn", bus.BERRn, 1);

    // Reset during ACK, then the wait table is back at its reset values.
    cyc(1'b0, 4'hE);
    cyc(1'b0, 4'hE);
    cyc(1'b0, 4'hE);
    chk("rst_pre_ack", bus.DTACKn, 0);
    apply(1, 0, 4'hE, 1, 1, 0, 0, 0);
    chk("rst_dtackn", bus.DTACKn, 1);
    chk("rst_berrn", bus.BERRn, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sel_idx", bus.sel_idx, 0);
    cyc(1'b1, 4'hF);
    for (int r = 0; r < 2; r++) begin
      logic [3:0] s;
      s = (r == 0) ? 4'hE : 4'hD;
      for (int i = 0; i < 4; i++) begin
        cyc(1'b0, s);
        chk($sformatf("rst_ws%0d_wait%0d", r, i), bus.DTACKn, 1);
      end
      cyc(1'b0, s);
      chk($sformatf("rst_ws%0d_ack", r), bus.DTACKn, 0);
      cyc(1'b1, s);
    end

    // Randomized cycles against an outcome model.
    apply(1, 1, 4'hF, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) ws_m[i] = 4'd2;
    begin
      int prev_sel;
      prev_sel = 0;
      for (int t = 0; t < 150; t++) begin
        int L, G, eidx, n, ack, ev, done;
        bit is_be;
        logic [3:0] sel;
        logic w [31];
        logic v [31];
        logic [NREG-1:0] ext_bits;
        ext_bits = EXT;
        L = $urandom_range(1, 24);
        G = $urandom_range(0, 2);
        sel = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
        for (int j = 0; j < 31; j++) begin
          w[j] = ($urandom_range(0, 3) != 0);
          v[j] = 1'($urandom_range(0, 1));
        end
        eidx = NREG;
        for (int i = NREG - 1; i >= 0; i--) if (!sel[i]) eidx = i;
        ack = 99; ev = 99; is_be = 1'b0; n = 0;
        for (int j = 0; j <= L + G; j++) begin
          logic we;
          logic [3:0] idx, val;
          we  = ($urandom_range(0, 7) == 0);
          idx = 4'($urandom_range(0, 5));
          val = 4'($urandom_range(0, 5));
          if (j == 1) begin
            // Ack edge: first edge >= k+2 with enough prior high-WAIT edges, WAIT high now, ext ready.
            if (eidx < NREG) begin
              n = ws_m[eidx];
              done = 0;
              for (int e = 2; e < 31; e++) begin
                if (done >= n && w[e] && (!ext_bits[eidx] || !v[e])) begin
                  ack = e;
                  break;
                end
                if (w[e]) done++;
              end
            end
            is_be = (1 + TMO <= ack);
            ev = is_be ? 1 + TMO : ack;
          end
          apply(0, (j < L) ? 1'b0 : 1'b1, sel, w[j], v[j], we, idx, val);
          if (we && idx < NREG) ws_m[idx] = val;
          if (j == 1) prev_sel = eidx;
          chk($sformatf("rnd%0d_e%0d_dtackn", t, j), bus.DTACKn,
              (!is_be && ev < L && j >= ev && j < L) ? 0 : 1);
          chk($sformatf("rnd%0d_e%0d_berrn", t, j), bus.BERRn,
              (is_be && ev < L && j >= ev && j < L) ? 0 : 1);
          chk($sformatf("rnd%0d_e%0d_busy", t, j), bus.busy, (j < L) ? 1 : 0);
          chk($sformatf("rnd%0d_e%0d_sel_idx", t, j), bus.sel_idx, prev_sel);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
